avmm_led_sequencer: RTL and testbench

// - Avalon-MM slave that receives the FPGA-side LED bus master port of soc_system and drives the 8 board LEDs.
// - HPS software programs a pattern and a mode. The block then produces static, blinking, rotating or PWM-dimmed LED output autonomously.
// - Sits directly downstream of soc_system: s0_* comes from its LED slave port; leds goes to the LED pins.

---
 rtl/led_seq_pkg.sv | 27 ++
 rtl/avmm_led_sequencer_if.sv | 25 ++
 rtl/led_seq_tick_gen.sv | 40 ++++
 rtl/avmm_led_sequencer.sv | 155 +++++++++++++++
 tb/tb_avmm_led_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED sequencer
// Purpose: mode enumeration, register word addresses, CTRL bit positions and
//          the prescaler terminal-count helper.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PATTERN = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_DUTY    = 2'd3;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_EN_BIT   = 8;

  // Last count value of the prescaler; PERIOD=0 behaves as PERIOD=1.
  function automatic logic [31:0] period_last(input logic [31:0] period);
    return (period == 32'd0) ? 32'd0 : period - 32'd1;
  endfunction

endpackage

// File: rtl/avmm_led_sequencer_if.sv
// rtl/avmm_led_sequencer_if.sv - Avalon-MM s0 port bundle for the LED sequencer
// Purpose: groups the s0_* slave signals.
// Signals: s0_address[1:0], s0_read, s0_readdata[DATA_W], s0_write, s0_writedata[DATA_W].
// Modports: master (bus driver), slave (the sequencer).
interface avmm_led_sequencer_if #(
  parameter int DATA_W = 32
) ();

  logic [1:0]        s0_address;
  logic              s0_read;
  logic [DATA_W-1:0] s0_readdata;
  logic              s0_write;
  logic [DATA_W-1:0] s0_writedata;

  modport master (
    output s0_address, s0_read, s0_write, s0_writedata,
    input  s0_readdata
  );

  modport slave (
    input  s0_address, s0_read, s0_write, s0_writedata,
    output s0_readdata
  );

endinterface

// File: rtl/led_seq_tick_gen.sv
// rtl/led_seq_tick_gen.sv - prescaler producing one-clock ticks every PERIOD clocks
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   period        clocks per tick (0 treated as 1)
//   clear         zeroes the counter this edge and suppresses the tick
//   tick          one-clock pulse in the cycle the counter wraps
module led_seq_tick_gen
  import led_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] period,
  input  logic        clear,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;

  // >= rather than == keeps the counter bounded if period ever shrinks
  // underneath it without a clear.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q >= period_last(period)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avmm_led_sequencer.sv
// rtl/avmm_led_sequencer.sv - Avalon-MM programmable LED pattern sequencer
// Purpose: register file (CTRL, PATTERN, PERIOD, DUTY), mode state machine
//          (static, blink, rotate, PWM) and registered LED drive.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   s0            Avalon-MM slave, no waitrequest, read latency 1
//   leds          registered LED drive, 1 = lit
module avmm_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int          LED_W      = 8,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] PERIOD_RST = 32'd50000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avmm_led_sequencer_if.slave  s0,
  output logic [LED_W-1:0]     leds
);

  mode_e             mode_q, mode_d;
  logic              en_q, en_d;
  logic [LED_W-1:0]  pattern_q, pattern_d;
  logic [31:0]       period_q, period_d;
  logic [7:0]        duty_q, duty_d;
  logic              phase_q, phase_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  logic [LED_W-1:0]  shreg_q, shreg_d;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic wr_ctrl, wr_pattern, wr_period, wr_duty;
  logic entry;
  logic tick_clear;
  logic tick;

  // Register writes and mode-entry detection. Kept apart from the sequencing
  // logic so tick_clear never depends on tick.
  always_comb begin
    wr_ctrl    = s0.s0_write && (s0.s0_address == REG_CTRL);
    wr_pattern = s0.s0_write && (s0.s0_address == REG_PATTERN);
    wr_period  = s0.s0_write && (s0.s0_address == REG_PERIOD);
    wr_duty    = s0.s0_write && (s0.s0_address == REG_DUTY);

    mode_d    = mode_q;
    en_d      = en_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    duty_d    = duty_q;

    if (wr_ctrl) begin
      mode_d = mode_e'(s0.s0_writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
      en_d   = s0.s0_writedata[CTRL_EN_BIT];
    end
    if (wr_pattern) pattern_d = s0.s0_writedata[LED_W-1:0];
    if (wr_period)  period_d  = s0.s0_writedata[31:0];
    if (wr_duty)    duty_d    = s0.s0_writedata[7:0];

    // A CTRL rewrite with the same mode and enable is not an entry.
    entry      = wr_ctrl && ((mode_d != mode_q) || (en_d && !en_q));
    tick_clear = entry || wr_period || !en_d;
  end

  led_seq_tick_gen u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .clear   (tick_clear),
    .tick    (tick)
  );

  // Mode state machine: the state is CTRL.mode gated by CTRL.enable.
  always_comb begin
    phase_d   = phase_q;
    pwm_cnt_d = pwm_cnt_q;
    shreg_d   = shreg_q;

    if (!en_d) begin
      phase_d   = 1'b0;
      pwm_cnt_d = '0;
    end else if (entry) begin
      phase_d   = 1'b1;
      pwm_cnt_d = '0;
      shreg_d   = pattern_q;
    end else if (tick) begin
      unique case (mode_q)
        MODE_STATIC: ;
        MODE_BLINK:  phase_d   = ~phase_q;
        MODE_SHIFT:  shreg_d   = {shreg_q[LED_W-2:0], shreg_q[LED_W-1]};
        MODE_PWM:    pwm_cnt_d = pwm_cnt_q + 8'd1;
      endcase
    end

    // A PATTERN write wins over a rotation on the same edge.
    if (wr_pattern) shreg_d = pattern_d;

    leds_d = '0;
    if (en_q) begin
      unique case (mode_q)
        MODE_STATIC: leds_d = pattern_q;
        MODE_BLINK:  leds_d = phase_q ? pattern_q : '0;
        MODE_SHIFT:  leds_d = shreg_q;
        MODE_PWM:    leds_d = (pwm_cnt_q < duty_q) ? pattern_q : '0;
      endcase
    end

    // Reads sample the pre-write register values; readdata holds between reads.
    readdata_d = readdata_q;
    if (s0.s0_read) begin
      readdata_d = '0;
      case (s0.s0_address)
        REG_CTRL: begin
          readdata_d[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
          readdata_d[CTRL_EN_BIT]                 = en_q;
        end
        REG_PATTERN: readdata_d[LED_W-1:0] = pattern_q;
        REG_PERIOD:  readdata_d[31:0]      = period_q;
        REG_DUTY: begin
          readdata_d[7:0]      = duty_q;
          readdata_d[8 +: LED_W] = leds_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_STATIC;
      en_q       <= 1'b0;
      pattern_q  <= '0;
      period_q   <= PERIOD_RST;
      duty_q     <= '0;
      phase_q    <= 1'b0;
      pwm_cnt_q  <= '0;
      shreg_q    <= '0;
      leds_q     <= '0;
      readdata_q <= '0;
    end else begin
      mode_q     <= mode_d;
      en_q       <= en_d;
      pattern_q  <= pattern_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      phase_q    <= phase_d;
      pwm_cnt_q  <= pwm_cnt_d;
      shreg_q    <= shreg_d;
      leds_q     <= leds_d;
      readdata_q <= readdata_d;
    end
  end

  assign leds           = leds_q;
  assign s0.s0_readdata = readdata_q;

endmodule

// File: tb/tb_avmm_led_sequencer.sv
// tb/tb_avmm_led_sequencer.sv - self-checking bench for avmm_led_sequencer
module tb_avmm_led_sequencer;

  localparam logic [1:0] A_CTRL = 2'd0, A_PAT = 2'd1, A_PER = 2'd2, A_DUTY = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] leds;

  always #5 clk = ~clk;

  avmm_led_sequencer_if #(.DATA_W(32)) s0 ();

  avmm_led_sequencer #(
    .LED_W      (8),
    .DATA_W     (32),
    .PERIOD_RST (32'd50000000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s0      (s0),
    .leds    (leds)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: LED output is computed from the number of ticks elapsed
  // since mode entry, derived arithmetically from clock counts.
  logic [1:0]  m_mode;
  bit          m_en;
  logic [7:0]  m_pat, m_duty, m_leds, m_shbase;
  logic [31:0] m_per, m_rd;
  int          m_n, m_c0, m_base, m_r0;

  function automatic int m_pmax();
    return (m_per == 0) ? 1 : int'(m_per);
  endfunction

  // Ticks since entry that have taken effect at edges <= e.
  function automatic int m_ticks(input int e);
    return m_base + (e - m_c0) / m_pmax();
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} << (k % 8);
    return t[15:8];
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_en = 1'b0; m_pat = 8'h00; m_duty = 8'h00;
    m_leds = 8'h00; m_shbase = 8'h00; m_per = 32'd50000000; m_rd = 32'h0;
    m_n = 0; m_c0 = 0; m_base = 0; m_r0 = 0;
  endtask

  task automatic model_edge(input logic [1:0] a, input bit r, input bit w, input logic [31:0] d);
    int         k;
    logic [7:0] nl;
    logic [1:0] nm;
    bit         ne;
    m_n++;
    k = m_ticks(m_n - 1);
    if (!m_en) nl = 8'h00;
    else case (m_mode)
      2'd0:    nl = m_pat;
      2'd1:    nl = (k % 2 == 0) ? m_pat : 8'h00;
      2'd2:    nl = rotl8(m_shbase, k - m_r0);
      default: nl = ((k % 256) < int'(m_duty)) ? m_pat : 8'h00;
    endcase
    if (r) case (a)
      A_CTRL:  m_rd = {23'd0, m_en, 6'd0, m_mode};
      A_PAT:   m_rd = {24'd0, m_pat};
      A_PER:   m_rd = m_per;
      default: m_rd = {16'd0, m_leds, m_duty};
    endcase
    m_leds = nl;
    if (w) case (a)
      A_CTRL: begin
        nm = d[1:0];
        ne = d[8];
        if ((nm != m_mode) || (ne && !m_en)) begin
          m_base = 0; m_c0 = m_n; m_shbase = m_pat; m_r0 = 0;
        end
        m_mode = nm;
        m_en   = ne;
      end
      A_PAT: begin
        m_pat    = d[7:0];
        m_shbase = d[7:0];
        m_r0     = m_ticks(m_n);
      end
      A_PER: begin
        m_base = m_base + (m_n - 1 - m_c0) / m_pmax();
        m_c0   = m_n;
        m_per  = d;
      end
      default: m_duty = d[7:0];
    endcase
  endtask

  task automatic cycle(input logic [1:0] a, input bit r, input bit w, input logic [31:0] d);
    s0.s0_address   = a;
    s0.s0_read      = r;
    s0.s0_write     = w;
    s0.s0_writedata = d;
    @(posedge clk);
    model_edge(a, r, w, d);
    #1;
    s0.s0_read  = 1'b0;
    s0.s0_write = 1'b0;
    chk("model_leds", {24'd0, leds}, {24'd0, m_leds});
    chk("model_readdata", s0.s0_readdata, m_rd);
  endtask

  task automatic idle();
    cycle(2'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]  a;
    bit          r;
    bit          w;
    logic [31:0] d;
    logic [7:0]  el;
    bit          cr;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] a, input bit r, input bit w, input logic [31:0] d,
                     input logic [7:0] el, input bit cr, input logic [31:0] er);
    vec_t v;
    v.a = a; v.r = r; v.w = w; v.d = d; v.el = el; v.cr = cr; v.er = er;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] sh_exp [9];
    int         on_cnt;
    logic [1:0] ra;
    logic [31:0] rd;
    bit         rr, rw;

    sh_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    // reset values, static, blink with PERIOD=0, DUTY readback
    add(A_CTRL, 1, 0, 32'h0,   8'h00, 1, 32'h0);
    add(A_PAT,  1, 0, 32'h0,   8'h00, 1, 32'h0);
    add(A_PER,  1, 0, 32'h0,   8'h00, 1, 32'd50000000);
    add(A_DUTY, 1, 0, 32'h0,   8'h00, 1, 32'h0);
    add(A_PAT,  0, 1, 32'hA5,  8'h00, 1, 32'h0);
    add(A_CTRL, 0, 1, 32'h100, 8'h00, 0, 32'h0);
    add(A_CTRL, 1, 0, 32'h0,   8'hA5, 1, 32'h100);
    add(A_CTRL, 0, 0, 32'h0,   8'hA5, 1, 32'h100);
    add(A_PER,  0, 1, 32'h0,   8'hA5, 0, 32'h0);
    add(A_PAT,  0, 1, 32'h0F,  8'hA5, 0, 32'h0);
    add(A_CTRL, 0, 1, 32'h101, 8'h0F, 0, 32'h0);
    add(A_CTRL, 0, 0, 32'h0,   8'h0F, 1, 32'h100);
    add(A_CTRL, 0, 0, 32'h0,   8'h00, 0, 32'h0);
    add(A_CTRL, 0, 0, 32'h0,   8'h0F, 0, 32'h0);
    add(A_CTRL, 0, 0, 32'h0,   8'h00, 0, 32'h0);
    add(A_PER,  1, 0, 32'h0,   8'h0F, 1, 32'h0);
    add(A_DUTY, 1, 0, 32'h0,   8'h00, 1, 32'h00000F00);

    s0.s0_address = 2'd0; s0.s0_read = 1'b0; s0.s0_write = 1'b0; s0.s0_writedata = 32'h0;
    do_reset();
    chk("reset_leds", {24'd0, leds}, 32'h0);
    chk("reset_readdata", s0.s0_readdata, 32'h0);

    foreach (tbl[i]) begin
      cycle(tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].d);
      chk($sformatf("vec%0d_leds", i), {24'd0, leds}, {24'd0, tbl[i].el});
      if (tbl[i].cr) chk($sformatf("vec%0d_readdata", i), s0.s0_readdata, tbl[i].er);
    end

    // SHIFT every 4 clocks with bit-7 wrap
    cycle(A_PER,  0, 1, 32'd4);
    cycle(A_PAT,  0, 1, 32'h81);
    cycle(A_CTRL, 0, 1, 32'h102);
    for (int i = 0; i < 36; i++) begin
      idle();
      chk($sformatf("shift_%0d", i), {24'd0, leds}, {24'd0, sh_exp[i / 4]});
    end

    // asynchronous reset mid-SHIFT
    reset_n = 1'b0;
    #1;
    chk("async_reset_leds", {24'd0, leds}, 32'h0);
    chk("async_reset_readdata", s0.s0_readdata, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // same-cycle read and write of PATTERN returns the old value
    cycle(A_PAT, 0, 1, 32'h81);
    cycle(A_PAT, 1, 1, 32'h3C);
    chk("rw_same_cycle_old", s0.s0_readdata, 32'h81);
    cycle(A_PAT, 1, 0, 32'h0);
    chk("rw_new_value", s0.s0_readdata, 32'h3C);

    // PWM 64/256 at PERIOD=1
    cycle(A_PER,  0, 1, 32'd1);
    cycle(A_PAT,  0, 1, 32'hFF);
    cycle(A_DUTY, 0, 1, 32'd64);
    cycle(A_CTRL, 0, 1, 32'h103);
    for (int i = 0; i < 512; i++) begin
      idle();
      chk($sformatf("pwm64_%0d", i), {24'd0, leds}, ((i % 256) < 64) ? 32'hFF : 32'h0);
    end

    // DUTY=255: on for 255 of 256 ticks
    cycle(A_CTRL, 0, 1, 32'h003);
    cycle(A_DUTY, 0, 1, 32'd255);
    cycle(A_CTRL, 0, 1, 32'h103);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle();
      if (leds != 8'h00) on_cnt++;
    end
    chk("pwm255_on_count", on_cnt, 255);

    // DUTY=0: always off
    cycle(A_DUTY, 0, 1, 32'd0);
    idle();
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle();
      if (leds != 8'h00) on_cnt++;
    end
    chk("pwm0_on_count", on_cnt, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ra = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 1) == 1);
      rw = ($urandom_range(0, 15) < 3);
      rd = $urandom;
      if (ra == A_PER)  rd = $urandom_range(0, 5);
      if (ra == A_CTRL) rd[8] = ($urandom_range(0, 3) != 0);
      cycle(ra, rr, rw, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
